// File: rtl/ledger_pkg.sv
// Shared opcodes, response codes, FSM states and sizing helper for the bank ledger responder.
package ledger_pkg;

  localparam logic [2:0] OP_BALANCE  = 3'b001;
  localparam logic [2:0] OP_WITHDRAW = 3'b010;
  localparam logic [2:0] OP_DEPOSIT  = 3'b011;
  localparam logic [2:0] OP_TRANSFER = 3'b100;

  typedef enum logic [2:0] {
    RS_OK           = 3'd0,
    RS_BAD_PIN      = 3'd1,
    RS_LOCKED       = 3'd2,
    RS_INSUFFICIENT = 3'd3,
    RS_OVERFLOW     = 3'd4,
    RS_BAD_OP       = 3'd5,
    RS_LIMIT        = 3'd6
  } status_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_EXEC,
    ST_RESP
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ledger_account_bank.sv
// Account table: balances, PIN try counters, lock bits and (with LEDGER_DAILY_LIMIT_EN) daily withdraw totals.
module ledger_account_bank
  import ledger_pkg::*;
#(
  parameter  int unsigned NUM_ACCOUNTS = 8,
  parameter  logic [31:0] INIT_BALANCE = 32'h000186A0,
  parameter  int unsigned TW           = 2,
  localparam int unsigned AW           = idx_width(NUM_ACCOUNTS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] src_idx,
  input  logic [AW-1:0] dst_idx,
  output logic [31:0]   src_bal,
  output logic [31:0]   dst_bal,
  output logic [TW-1:0] src_tries,
  output logic          src_lock,
  input  logic          tries_we,
  input  logic [TW-1:0] tries_wd,
  input  logic          lock_set,
`ifdef LEDGER_DAILY_LIMIT_EN
  output logic [31:0]   src_daily,
  input  logic          daily_we,
  input  logic [31:0]   daily_wd,
  input  logic          rollover,
`endif
  input  logic          src_we,
  input  logic [31:0]   src_wd,
  input  logic          dst_we,
  input  logic [31:0]   dst_wd
);

  logic [31:0]             bal_q   [NUM_ACCOUNTS];
  logic [31:0]             bal_d   [NUM_ACCOUNTS];
  logic [TW-1:0]           tries_q [NUM_ACCOUNTS];
  logic [TW-1:0]           tries_d [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] lock_q;
  logic [NUM_ACCOUNTS-1:0] lock_d;

  assign src_bal   = bal_q[src_idx];
  assign dst_bal   = bal_q[dst_idx];
  assign src_tries = tries_q[src_idx];
  assign src_lock  = lock_q[src_idx];

  always_comb begin
    bal_d   = bal_q;
    tries_d = tries_q;
    lock_d  = lock_q;
    if (src_we)   bal_d[src_idx]   = src_wd;
    if (dst_we)   bal_d[dst_idx]   = dst_wd;
    if (tries_we) tries_d[src_idx] = tries_wd;
    if (lock_set) lock_d[src_idx]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bal_q   <= '{default: INIT_BALANCE};
      tries_q <= '{default: '0};
      lock_q  <= '0;
    end else begin
      bal_q   <= bal_d;
      tries_q <= tries_d;
      lock_q  <= lock_d;
    end
  end

`ifdef LEDGER_DAILY_LIMIT_EN
  logic [31:0] daily_q [NUM_ACCOUNTS];
  logic [31:0] daily_d [NUM_ACCOUNTS];

  assign src_daily = daily_q[src_idx];

  // A rollover in the same cycle as a counted withdraw drops that amount.
  always_comb begin
    daily_d = daily_q;
    if (rollover)      daily_d = '{default: '0};
    else if (daily_we) daily_d[src_idx] = daily_wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) daily_q <= '{default: '0};
    else        daily_q <= daily_d;
  end
`endif

endmodule

// File: rtl/bank_ledger_responder.sv
// Transaction FSM and datapath for the ledger responder; LEDGER_DAILY_LIMIT_EN enables per-account daily withdraw caps.
module bank_ledger_responder
  import ledger_pkg::*;
#(
  parameter  int unsigned NUM_ACCOUNTS = 8,
  parameter  logic [31:0] INIT_BALANCE = 32'h000186A0,
  parameter  logic [13:0] INIT_PIN     = 14'd8030,
  parameter  int unsigned MAX_TRIES    = 3,
  parameter  logic [31:0] DAILY_LIMIT  = 32'd20000,
  localparam int unsigned AW           = idx_width(NUM_ACCOUNTS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_opcode,
  input  logic [AW-1:0] req_acct,
  input  logic [AW-1:0] req_dst_acct,
  input  logic [13:0]   req_pin,
  input  logic [31:0]   req_amount,
  input  logic          day_rollover,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [2:0]    rsp_status,
  output logic [31:0]   rsp_balance
);

  localparam int unsigned TW = idx_width(MAX_TRIES + 1);

  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] acct_q, acct_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [13:0]   pin_q, pin_d;
  logic [31:0]   amt_q, amt_d;
  status_e       status_q, status_d;
  logic [31:0]   rbal_q, rbal_d;

  logic [31:0]   src_bal, dst_bal, src_wd, dst_wd;
  logic [TW-1:0] src_tries, tries_wd, tries_inc;
  logic          src_lock, src_we, dst_we, tries_we, lock_set, count_day;
  logic [32:0]   dep_sum, dst_sum;
  logic          short_funds, hit_max, pin_ok, op_legal, over_limit;

  assign dep_sum     = {1'b0, src_bal} + {1'b0, amt_q};
  assign dst_sum     = {1'b0, dst_bal} + {1'b0, amt_q};
  assign short_funds = amt_q > src_bal;
  assign tries_inc   = src_tries + 1'b1;
  assign hit_max     = 32'(tries_inc) >= MAX_TRIES;
  assign pin_ok      = pin_q == (INIT_PIN + 14'(acct_q));
  assign op_legal    = op_q inside {OP_BALANCE, OP_WITHDRAW, OP_DEPOSIT, OP_TRANSFER};

`ifdef LEDGER_DAILY_LIMIT_EN
  logic [31:0] src_daily, day_sat;
  logic [32:0] day_sum;
  assign day_sum    = {1'b0, src_daily} + {1'b0, amt_q};
  assign over_limit = day_sum > {1'b0, DAILY_LIMIT};
  assign day_sat    = day_sum[32] ? '1 : day_sum[31:0];
`else
  logic unused_day;
  assign over_limit = 1'b0;
  assign unused_day = ^{count_day, day_rollover, DAILY_LIMIT};
`endif

  ledger_account_bank #(
    .NUM_ACCOUNTS (NUM_ACCOUNTS),
    .INIT_BALANCE (INIT_BALANCE),
    .TW           (TW)
  ) u_bank (
    .clk       (clk),
    .rst_n     (reset),
    .src_idx   (acct_q),
    .dst_idx   (dst_q),
    .src_bal   (src_bal),
    .dst_bal   (dst_bal),
    .src_tries (src_tries),
    .src_lock  (src_lock),
    .tries_we  (tries_we),
    .tries_wd  (tries_wd),
    .lock_set  (lock_set),
`ifdef LEDGER_DAILY_LIMIT_EN
    .src_daily (src_daily),
    .daily_we  (count_day),
    .daily_wd  (day_sat),
    .rollover  (day_rollover),
`endif
    .src_we    (src_we),
    .src_wd    (src_wd),
    .dst_we    (dst_we),
    .dst_wd    (dst_wd)
  );

  assign req_ready   = state_q == ST_IDLE;
  assign rsp_valid   = state_q == ST_RESP;
  assign rsp_status  = status_q;
  assign rsp_balance = rbal_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    acct_d    = acct_q;
    dst_d     = dst_q;
    pin_d     = pin_q;
    amt_d     = amt_q;
    status_d  = status_q;
    rbal_d    = rbal_q;
    src_we    = 1'b0;
    src_wd    = src_bal;
    dst_we    = 1'b0;
    dst_wd    = dst_bal;
    tries_we  = 1'b0;
    tries_wd  = src_tries;
    lock_set  = 1'b0;
    count_day = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_opcode;
          acct_d  = req_acct;
          dst_d   = req_dst_acct;
          pin_d   = req_pin;
          amt_d   = req_amount;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        state_d = ST_RESP;
        rbal_d  = src_bal;
        if (!op_legal) begin
          status_d = RS_BAD_OP;
        end else if (src_lock) begin
          status_d = RS_LOCKED;
        end else if (!pin_ok) begin
          tries_we = 1'b1;
          tries_wd = tries_inc;
          lock_set = hit_max;
          status_d = hit_max ? RS_LOCKED : RS_BAD_PIN;
        end else if (op_q == OP_TRANSFER && dst_q == acct_q) begin
          status_d = RS_BAD_OP;
        end else begin
          tries_we = 1'b1;
          tries_wd = '0;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d  = ST_RESP;
        status_d = RS_OK;
        rbal_d   = src_bal;
        unique case (op_q)
          OP_WITHDRAW: begin
            if (short_funds)     status_d = RS_INSUFFICIENT;
            else if (over_limit) status_d = RS_LIMIT;
            else begin
              src_we    = 1'b1;
              src_wd    = src_bal - amt_q;
              rbal_d    = src_wd;
              count_day = 1'b1;
            end
          end
          OP_DEPOSIT: begin
            if (dep_sum[32]) status_d = RS_OVERFLOW;
            else begin
              src_we = 1'b1;
              src_wd = dep_sum[31:0];
              rbal_d = src_wd;
            end
          end
          OP_TRANSFER: begin
            if (short_funds)      status_d = RS_INSUFFICIENT;
            else if (over_limit)  status_d = RS_LIMIT;
            else if (dst_sum[32]) status_d = RS_OVERFLOW;
            else begin
              src_we    = 1'b1;
              src_wd    = src_bal - amt_q;
              dst_we    = 1'b1;
              dst_wd    = dst_sum[31:0];
              rbal_d    = src_wd;
              count_day = 1'b1;
            end
          end
          default: ;
        endcase
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      acct_q   <= '0;
      dst_q    <= '0;
      pin_q    <= '0;
      amt_q    <= '0;
      status_q <= RS_OK;
      rbal_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acct_q   <= acct_d;
      dst_q    <= dst_d;
      pin_q    <= pin_d;
      amt_q    <= amt_d;
      status_q <= status_d;
      rbal_q   <= rbal_d;
    end
  end

endmodule

// File: tb/tb_bank_ledger_responder.sv
// Directed self-checking bench for bank_ledger_responder with an account-level reference model.
module tb_bank_ledger_responder;

  localparam int unsigned N = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_opcode = '0;
  logic [2:0]  req_acct = '0;
  logic [2:0]  req_dst_acct = '0;
  logic [13:0] req_pin = '0;
  logic [31:0] req_amount = '0;
  logic        day_rollover = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [2:0]  rsp_status;
  logic [31:0] rsp_balance;

  bank_ledger_responder #(
    .NUM_ACCOUNTS (N),
    .INIT_BALANCE (32'h000186A0),
    .INIT_PIN     (14'd8030),
    .MAX_TRIES    (3),
    .DAILY_LIMIT  (32'd20000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_opcode   (req_opcode),
    .req_acct     (req_acct),
    .req_dst_acct (req_dst_acct),
    .req_pin      (req_pin),
    .req_amount   (req_amount),
    .day_rollover (day_rollover),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_status   (rsp_status),
    .rsp_balance  (rsp_balance)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  longint m_bal   [N];
  int     m_tries [N];
  bit     m_lock  [N];
  longint m_daily [N];

  logic [2:0]  exp_status = '0;
  logic [31:0] exp_bal = '0;
  bit          expect_rsp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_bal[i]   = 100000;
      m_tries[i] = 0;
      m_lock[i]  = 1'b0;
      m_daily[i] = 0;
    end
  endtask

  function automatic bit limit_hit(input int acct, input longint amt);
`ifdef LEDGER_DAILY_LIMIT_EN
    return (m_daily[acct] + amt) > 20000;
`else
    return 1'b0;
`endif
  endfunction

  task automatic count_daily(input int acct, input longint amt);
    m_daily[acct] = m_daily[acct] + amt;
    if (m_daily[acct] > 64'hFFFF_FFFF) m_daily[acct] = 64'hFFFF_FFFF;
  endtask

  // Outcome of one transaction from the account rules; updates the model table.
  task automatic model_txn(input int op, input int acct, input int dst, input int pin,
                           input longint amt, output logic [2:0] st, output logic [31:0] bal);
    longint b;
    b  = m_bal[acct];
    st = 3'd0;
    if (op < 1 || op > 4) st = 3'd5;
    else if (m_lock[acct]) st = 3'd2;
    else if (pin != (8030 + acct) % 16384) begin
      m_tries[acct]++;
      if (m_tries[acct] >= 3) begin
        m_lock[acct] = 1'b1;
        st = 3'd2;
      end else st = 3'd1;
    end else if (op == 4 && dst == acct) st = 3'd5;
    else begin
      m_tries[acct] = 0;
      if (op == 2) begin
        if (amt > b) st = 3'd3;
        else if (limit_hit(acct, amt)) st = 3'd6;
        else begin
          m_bal[acct] = b - amt;
          count_daily(acct, amt);
        end
      end else if (op == 3) begin
        if (b + amt > 64'hFFFF_FFFF) st = 3'd4;
        else m_bal[acct] = b + amt;
      end else if (op == 4) begin
        if (amt > b) st = 3'd3;
        else if (limit_hit(acct, amt)) st = 3'd6;
        else if (m_bal[dst] + amt > 64'hFFFF_FFFF) st = 3'd4;
        else begin
          m_bal[acct] = b - amt;
          m_bal[dst]  = m_bal[dst] + amt;
          count_daily(acct, amt);
        end
      end
    end
    bal = 32'(m_bal[acct]);
  endtask

  // Single compare process: any visible response must match the model.
  always @(negedge clk) begin
    if (reset && expect_rsp && rsp_valid) begin
      check("rsp_status", 64'(rsp_status), 64'(exp_status));
      check("rsp_balance", 64'(rsp_balance), 64'(exp_bal));
      check("req_ready_in_resp", 64'(req_ready), 64'd0);
    end
  end

  task automatic send_req(input int op, input int acct, input int dst, input int pin, input longint amt);
    int t;
    @(negedge clk);
    req_opcode   = 3'(op);
    req_acct     = 3'(acct);
    req_dst_acct = 3'(dst);
    req_pin      = 14'(pin);
    req_amount   = 32'(amt);
    req_valid    = 1'b1;
    t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) check("req_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_opcode   = 3'($urandom);
    req_acct     = 3'($urandom);
    req_dst_acct = 3'($urandom);
    req_pin      = 14'($urandom);
    req_amount   = $urandom;
  endtask

  task automatic do_txn(input int op, input int acct, input int dst, input int pin, input longint amt,
                        input logic [2:0] lit_st, input logic [31:0] lit_bal,
                        input int hold, input bit check_lat);
    logic [2:0]  ms;
    logic [31:0] mb;
    int          edges;
    model_txn(op, acct, dst, pin, amt, ms, mb);
    check("model_status", 64'(ms), 64'(lit_st));
    check("model_balance", 64'(mb), 64'(lit_bal));
    exp_status = ms;
    exp_bal    = mb;
    expect_rsp = 1'b1;
    send_req(op, acct, dst, pin, amt);
    edges = 0;
    while (!rsp_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!rsp_valid) check("rsp_valid_timeout", 64'd0, 64'd1);
    if (check_lat) check("latency_cycles", 64'(edges + 1), 64'd3);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("rsp_valid_held", 64'(rsp_valid), 64'd1);
      check("req_ready_held", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready  = 1'b0;
    expect_rsp = 1'b0;
    check("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    check("req_ready_back", 64'(req_ready), 64'd1);
  endtask

  initial begin
    model_reset();
    #2;
    check("reset_req_ready", 64'(req_ready), 64'd1);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_status", 64'(rsp_status), 64'd0);
    check("reset_rsp_balance", 64'(rsp_balance), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    do_txn(1, 0, 0, 8030, 0, 3'd0, 32'd100000, 0, 1'b1);
    do_txn(2, 1, 0, 8031, 30000, 3'd0, 32'd70000, 0, 1'b1);
    do_txn(2, 1, 0, 8031, 80000, 3'd3, 32'd70000, 0, 1'b0);
    do_txn(2, 1, 0, 8031, 0, 3'd0, 32'd70000, 0, 1'b0);
    do_txn(1, 2, 0, 1234, 0, 3'd1, 32'd100000, 0, 1'b0);
    do_txn(1, 2, 0, 1234, 0, 3'd1, 32'd100000, 0, 1'b0);
    do_txn(1, 2, 0, 1234, 0, 3'd2, 32'd100000, 0, 1'b0);
    do_txn(1, 2, 0, 8032, 0, 3'd2, 32'd100000, 0, 1'b0);
    do_txn(4, 3, 4, 8033, 40000, 3'd0, 32'd60000, 0, 1'b0);
    do_txn(1, 4, 0, 8034, 0, 3'd0, 32'd140000, 0, 1'b0);
    do_txn(4, 3, 3, 8033, 1, 3'd5, 32'd60000, 0, 1'b0);
    do_txn(4, 3, 4, 8033, 70000, 3'd3, 32'd60000, 0, 1'b0);
    do_txn(3, 5, 0, 8035, 64'hFFFF0000, 3'd4, 32'd100000, 0, 1'b0);
    do_txn(3, 5, 0, 8035, 1000, 3'd0, 32'd101000, 0, 1'b0);
    do_txn(7, 0, 0, 8030, 5, 3'd5, 32'd100000, 0, 1'b0);
    do_txn(0, 0, 0, 8030, 5, 3'd5, 32'd100000, 0, 1'b0);
    do_txn(1, 0, 0, 8030, 0, 3'd0, 32'd100000, 5, 1'b0);

`ifdef LEDGER_DAILY_LIMIT_EN
    do_txn(2, 7, 0, 8037, 15000, 3'd0, 32'd85000, 0, 1'b0);
    do_txn(2, 7, 0, 8037, 6000, 3'd6, 32'd85000, 0, 1'b0);
    @(negedge clk);
    day_rollover = 1'b1;
    @(negedge clk);
    day_rollover = 1'b0;
    for (int i = 0; i < N; i++) m_daily[i] = 0;
    do_txn(2, 7, 0, 8037, 6000, 3'd0, 32'd79000, 0, 1'b0);
`endif

    // Abort a withdraw while it sits in EXEC; the table must come back clean.
    send_req(2, 6, 0, 8036, 1000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_req_ready", 64'(req_ready), 64'd1);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort_rsp_status", 64'(rsp_status), 64'd0);
    check("abort_rsp_balance", 64'(rsp_balance), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    do_txn(1, 6, 0, 8036, 0, 3'd0, 32'd100000, 0, 1'b1);
    do_txn(1, 1, 0, 8031, 0, 3'd0, 32'd100000, 0, 1'b0);
    do_txn(1, 2, 0, 8032, 0, 3'd0, 32'd100000, 0, 1'b0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, required finished");
    $fatal(1);
  end

endmodule
